// File: rtl/floo_mcast_resp_join_pkg.sv
// Shared types and helpers for the multicast response join: AXI B codes,
// the table entry layout and the response-severity merge.
package floo_mcast_resp_join_pkg;

   localparam logic [1:0] RespOkay   = 2'd0;
   localparam logic [1:0] RespExOkay = 2'd1;
   localparam logic [1:0] RespSlvErr = 2'd2;
   localparam logic [1:0] RespDecErr = 2'd3;

   localparam int unsigned DefNumDests      = 4;
   localparam int unsigned DefMaxOutstanding = 4;
   localparam int unsigned DefIdWidth       = 8;
   localparam int unsigned DefCntWidth      = $clog2(DefNumDests + 1);

   typedef struct packed {
      logic                   vld;
      logic [DefIdWidth-1:0]  id;
      logic [DefCntWidth-1:0] remaining;
      logic [1:0]             resp;
   } mcast_entry_t;

   // Codes are ordered by severity, so the merge is a numeric maximum.
   function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/floo_mcast_id_cam.sv
// Combinational ID match of the incoming response and the new registration
// against all live table entries; returns one-hot hit vectors.
module floo_mcast_id_cam #(
   parameter int unsigned NumEntries = 4,
   parameter int unsigned IdWidth    = 8
) (
   input  logic [NumEntries-1:0]              live,
   input  logic [NumEntries-1:0][IdWidth-1:0] entry_id,
   input  logic [IdWidth-1:0]                 resp_id,
   input  logic [IdWidth-1:0]                 expect_id,
   output logic [NumEntries-1:0]              resp_hit,
   output logic [NumEntries-1:0]              expect_hit
);

   for (genvar gi = 0; gi < NumEntries; gi++) begin : g_match
      assign resp_hit[gi]   = live[gi] && (entry_id[gi] == resp_id);
      assign expect_hit[gi] = live[gi] && (entry_id[gi] == expect_id);
   end

endmodule

// File: rtl/floo_mcast_resp_join.sv
// Joins the per-destination B responses of a multicast write into one merged
// response, releasing completed transactions strictly in registration order.
module floo_mcast_resp_join
   import floo_mcast_resp_join_pkg::*;
#(
   parameter int unsigned NumDests       = DefNumDests,
   parameter int unsigned MaxOutstanding = DefMaxOutstanding,
   parameter int unsigned IdWidth        = DefIdWidth,
   parameter int unsigned CntWidth       = $clog2(NumDests + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                expect_valid_i,
   output logic                expect_ready_o,
   input  logic [IdWidth-1:0]  expect_id_i,
   input  logic [CntWidth-1:0] expect_cnt_i,
   input  logic                resp_valid_i,
   output logic                resp_ready_o,
   input  logic [IdWidth-1:0]  resp_id_i,
   input  logic [1:0]          resp_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [IdWidth-1:0]  out_id_o,
   output logic [1:0]          out_resp_o,
   output logic                unmatched_o
);

   typedef logic [IdWidth-1:0] id_t;

   localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned OccWidth = $clog2(MaxOutstanding + 1);

   typedef struct packed {
      logic                vld;
      id_t                 id;
      logic [CntWidth-1:0] remaining;
      logic [1:0]          resp;
   } entry_t;

   entry_t               entry_reg  [MaxOutstanding];
   entry_t               entry_next [MaxOutstanding];
   logic [PtrWidth-1:0]  head_reg, head_next;
   logic [PtrWidth-1:0]  tail_reg, tail_next;
   logic [OccWidth-1:0]  occ_reg, occ_next;
   logic                 unmatched_reg;

   logic [MaxOutstanding-1:0]              live;
   logic [MaxOutstanding-1:0][IdWidth-1:0] entry_id;
   logic [MaxOutstanding-1:0]              resp_hit;
   logic [MaxOutstanding-1:0]              expect_hit;
   entry_t                                 head_entry;
   logic                                   alloc_fire, resp_fire, pop_fire;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   // Only entries still collecting responses take part in matching; a
   // completed entry waiting for release may share its ID with a new one.
   for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_cam_in
      assign live[gi]     = entry_reg[gi].vld && (entry_reg[gi].remaining != '0);
      assign entry_id[gi] = entry_reg[gi].id;
   end

   floo_mcast_id_cam #(
      .NumEntries (MaxOutstanding),
      .IdWidth    (IdWidth)
   ) i_id_cam (
      .live       (live),
      .entry_id   (entry_id),
      .resp_id    (resp_id_i),
      .expect_id  (expect_id_i),
      .resp_hit   (resp_hit),
      .expect_hit (expect_hit)
   );

   assign head_entry     = entry_reg[head_reg];
   assign expect_ready_o = !rst_i && (occ_reg < OccWidth'(MaxOutstanding)) && !(|expect_hit);
   assign resp_ready_o   = !rst_i;
   assign out_valid_o    = !rst_i && head_entry.vld && (head_entry.remaining == '0);
   assign out_id_o       = head_entry.id;
   assign out_resp_o     = head_entry.resp;
   assign unmatched_o    = !rst_i && unmatched_reg;

   assign alloc_fire = expect_valid_i && expect_ready_o;
   assign resp_fire  = resp_valid_i && resp_ready_o;
   assign pop_fire   = out_valid_o && out_ready_i;

   // Matching uses registered state, so an entry written this cycle can never
   // absorb a response arriving in the same cycle. Alloc, pop and the matched
   // entry are always distinct slots.
   always_comb begin
      for (int i = 0; i < MaxOutstanding; i++) begin
         entry_next[i] = entry_reg[i];
         if (resp_fire && resp_hit[i]) begin
            entry_next[i].remaining = entry_reg[i].remaining - CntWidth'(1);
            entry_next[i].resp      = resp_merge(entry_reg[i].resp, resp_i);
         end
         if (alloc_fire && (tail_reg == PtrWidth'(i))) begin
            entry_next[i] = '{vld: 1'b1, id: expect_id_i, remaining: expect_cnt_i, resp: RespOkay};
         end
         if (pop_fire && (head_reg == PtrWidth'(i))) begin
            entry_next[i] = '0;
         end
      end
   end

   always_comb begin
      head_next = pop_fire   ? ptr_inc(head_reg) : head_reg;
      tail_next = alloc_fire ? ptr_inc(tail_reg) : tail_reg;
      occ_next  = occ_reg;
      case ({alloc_fire, pop_fire})
         2'b10:   occ_next = occ_reg + OccWidth'(1);
         2'b01:   occ_next = occ_reg - OccWidth'(1);
         default: occ_next = occ_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MaxOutstanding; i++) begin
            entry_reg[i] <= '0;
         end
         head_reg      <= '0;
         tail_reg      <= '0;
         occ_reg       <= '0;
         unmatched_reg <= 1'b0;
      end else begin
         for (int i = 0; i < MaxOutstanding; i++) begin
            entry_reg[i] <= entry_next[i];
         end
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         occ_reg       <= occ_next;
         unmatched_reg <= resp_fire && !(|resp_hit);
      end
   end

   a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
      alloc_fire |-> (expect_cnt_i <= CntWidth'(NumDests)));

   a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=>
         (out_valid_o && $stable(out_id_o) && $stable(out_resp_o)));

   a_resp_unique: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(resp_hit));

   a_expect_unique: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(expect_hit));

   for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_chk
      a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
         (resp_fire && resp_hit[gi]) |-> (entry_reg[gi].remaining != '0));
   end

endmodule

// File: tb/tb_floo_mcast_resp_join.sv
// Directed bench for floo_mcast_resp_join: merging, in-order release, full
// table, unmatched drop, zero-count entries and mid-operation reset.
module tb_floo_mcast_resp_join;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       expect_valid_i;
   logic       expect_ready_o;
   logic [7:0] expect_id_i;
   logic [2:0] expect_cnt_i;
   logic       resp_valid_i;
   logic       resp_ready_o;
   logic [7:0] resp_id_i;
   logic [1:0] resp_i;
   logic       out_valid_o;
   logic       out_ready_i;
   logic [7:0] out_id_o;
   logic [1:0] out_resp_o;
   logic       unmatched_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   floo_mcast_resp_join dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .expect_valid_i (expect_valid_i),
      .expect_ready_o (expect_ready_o),
      .expect_id_i    (expect_id_i),
      .expect_cnt_i   (expect_cnt_i),
      .resp_valid_i   (resp_valid_i),
      .resp_ready_o   (resp_ready_o),
      .resp_id_i      (resp_id_i),
      .resp_i         (resp_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_id_o       (out_id_o),
      .out_resp_o     (out_resp_o),
      .unmatched_o    (unmatched_o)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] order [4];
      order = '{8'h21, 8'h22, 8'h23, 8'h30};

      rst_i = 1'b1;
      expect_valid_i = 1'b0; expect_id_i = '0; expect_cnt_i = '0;
      resp_valid_i = 1'b0; resp_id_i = '0; resp_i = '0;
      out_ready_i = 1'b0;
      tick();
      chk("rst_expect_ready", 32'(expect_ready_o), 0);
      chk("rst_resp_ready", 32'(resp_ready_o), 0);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_unmatched", 32'(unmatched_o), 0);
      rst_i = 1'b0;
      #1;
      chk("idle_expect_ready", 32'(expect_ready_o), 1);
      chk("idle_resp_ready", 32'(resp_ready_o), 1);

      // Merge of three responses into SLVERR
      expect_valid_i = 1'b1; expect_id_i = 8'h12; expect_cnt_i = 3'd3;
      tick();
      expect_valid_i = 1'b0;
      resp_valid_i = 1'b1; resp_id_i = 8'h12; resp_i = 2'd0;
      tick();
      resp_i = 2'd2;
      tick();
      resp_i = 2'd0;
      #1;
      chk("t1_not_done", 32'(out_valid_o), 0);
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t1_out_valid", 32'(out_valid_o), 1);
      chk("t1_out_id", 32'(out_id_o), 32'h12);
      chk("t1_out_resp", 32'(out_resp_o), 2);
      chk("t1_unmatched", 32'(unmatched_o), 0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      #1;
      chk("t1_single_pop", 32'(out_valid_o), 0);

      // In-order release when the younger entry completes first
      expect_valid_i = 1'b1; expect_id_i = 8'h01; expect_cnt_i = 3'd2;
      tick();
      expect_id_i = 8'h02; expect_cnt_i = 3'd1;
      tick();
      expect_valid_i = 1'b0;
      resp_valid_i = 1'b1; resp_id_i = 8'h02; resp_i = 2'd1;
      tick();
      chk("t2_wait_head", 32'(out_valid_o), 0);
      resp_id_i = 8'h01; resp_i = 2'd0;
      tick();
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t2_first_valid", 32'(out_valid_o), 1);
      chk("t2_first_id", 32'(out_id_o), 32'h01);
      chk("t2_first_resp", 32'(out_resp_o), 0);
      out_ready_i = 1'b1;
      tick();
      chk("t2_second_valid", 32'(out_valid_o), 1);
      chk("t2_second_id", 32'(out_id_o), 32'h02);
      chk("t2_second_resp", 32'(out_resp_o), 1);
      tick();
      out_ready_i = 1'b0;
      #1;
      chk("t2_drained", 32'(out_valid_o), 0);

      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;

      // Fill the table, free the head, allocate at the wrapped tail
      for (int i = 0; i < 4; i++) begin
         expect_valid_i = 1'b1; expect_id_i = 8'h20 + 8'(i); expect_cnt_i = 3'd1;
         #1;
         chk($sformatf("t3_fill_ready_%0d", i), 32'(expect_ready_o), 1);
         tick();
      end
      expect_id_i = 8'h30;
      #1;
      chk("t3_full_ready", 32'(expect_ready_o), 0);
      resp_valid_i = 1'b1; resp_id_i = 8'h20; resp_i = 2'd0;
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t3_head_valid", 32'(out_valid_o), 1);
      chk("t3_head_id", 32'(out_id_o), 32'h20);
      chk("t3_full_before_pop", 32'(expect_ready_o), 0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      expect_id_i = 8'h21;
      #1;
      chk("t3_dup_stall", 32'(expect_ready_o), 0);
      expect_id_i = 8'h30;
      #1;
      chk("t3_ready_after_free", 32'(expect_ready_o), 1);
      tick();
      expect_valid_i = 1'b0;
      resp_valid_i = 1'b1;
      resp_id_i = 8'h30; tick();
      resp_id_i = 8'h23; tick();
      resp_id_i = 8'h22; tick();
      chk("t3_head_pending", 32'(out_valid_o), 0);
      resp_id_i = 8'h21; tick();
      resp_valid_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_drain_valid_%0d", i), 32'(out_valid_o), 1);
         chk($sformatf("t3_drain_id_%0d", i), 32'(out_id_o), 32'(order[i]));
         tick();
      end
      out_ready_i = 1'b0;
      #1;
      chk("t3_empty", 32'(out_valid_o), 0);

      // Unmatched response is dropped
      resp_valid_i = 1'b1; resp_id_i = 8'h55; resp_i = 2'd3;
      #1;
      chk("t4_resp_ready", 32'(resp_ready_o), 1);
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t4_unmatched_pulse", 32'(unmatched_o), 1);
      chk("t4_no_out", 32'(out_valid_o), 0);
      tick();
      chk("t4_unmatched_clear", 32'(unmatched_o), 0);
      chk("t4_table_free", 32'(expect_ready_o), 1);

      // Zero-count entry completes at once and holds under backpressure
      expect_valid_i = 1'b1; expect_id_i = 8'h07; expect_cnt_i = 3'd0;
      tick();
      expect_valid_i = 1'b0;
      #1;
      chk("t5_valid", 32'(out_valid_o), 1);
      chk("t5_id", 32'(out_id_o), 32'h07);
      chk("t5_resp", 32'(out_resp_o), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_hold_valid_%0d", i), 32'(out_valid_o), 1);
         chk($sformatf("t5_hold_id_%0d", i), 32'(out_id_o), 32'h07);
         chk($sformatf("t5_hold_resp_%0d", i), 32'(out_resp_o), 0);
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      #1;
      chk("t5_popped", 32'(out_valid_o), 0);

      // Reset mid-transaction discards the entry
      expect_valid_i = 1'b1; expect_id_i = 8'h09; expect_cnt_i = 3'd2;
      tick();
      expect_valid_i = 1'b0;
      resp_valid_i = 1'b1; resp_id_i = 8'h09; resp_i = 2'd3;
      tick();
      resp_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_expect_ready", 32'(expect_ready_o), 0);
      chk("t6_rst_resp_ready", 32'(resp_ready_o), 0);
      chk("t6_rst_out_valid", 32'(out_valid_o), 0);
      chk("t6_rst_unmatched", 32'(unmatched_o), 0);
      tick();
      rst_i = 1'b0;
      resp_valid_i = 1'b1; resp_id_i = 8'h09; resp_i = 2'd0;
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t6_late_unmatched", 32'(unmatched_o), 1);
      chk("t6_late_no_out", 32'(out_valid_o), 0);
      tick();
      chk("t6_quiet_unmatched", 32'(unmatched_o), 0);
      chk("t6_quiet_out", 32'(out_valid_o), 0);

      // Response in the allocation cycle must not hit the new entry
      expect_valid_i = 1'b1; expect_id_i = 8'h0A; expect_cnt_i = 3'd1;
      resp_valid_i = 1'b1; resp_id_i = 8'h0A; resp_i = 2'd2;
      tick();
      expect_valid_i = 1'b0;
      resp_valid_i = 1'b0;
      #1;
      chk("t7_same_cycle_unmatched", 32'(unmatched_o), 1);
      chk("t7_same_cycle_no_out", 32'(out_valid_o), 0);
      resp_valid_i = 1'b1; resp_id_i = 8'h0A; resp_i = 2'd0;
      tick();
      resp_valid_i = 1'b0;
      #1;
      chk("t7_valid", 32'(out_valid_o), 1);
      chk("t7_id", 32'(out_id_o), 32'h0A);
      chk("t7_resp", 32'(out_resp_o), 0);
      chk("t7_matched", 32'(unmatched_o), 0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/floo_mcast_resp_join.md
Name: floo_mcast_resp_join

Overview:
- Collects the individual responses returned by each destination of a ring-on-mesh multicast write.
- Merges them into a single response toward the initiating network interface. This is the join counterpart of the router-side multicast fork.
- Sits in the NI response path. The request side registers each outgoing multicast with its expected response count.
- Tracks up to MaxOutstanding transactions and releases merged responses in allocation order.

Parameters:
- NumDests, 4, maximum number of destinations per multicast.
- MaxOutstanding, 4, table entries (concurrent multicasts).
- IdWidth, 8, transaction ID width.
- id_t, logic[IdWidth-1:0], transaction ID type.
- CntWidth, $clog2(NumDests+1), expected-count width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- expect_valid_i  in  1  register a new multicast.
- expect_ready_o  out  1  table can accept the registration.
- expect_id_i  in  IdWidth  transaction ID.
- expect_cnt_i  in  CntWidth  number of responses to collect.
- resp_valid_i  in  1  individual destination response.
- resp_ready_o  out  1  response accepted.
- resp_id_i  in  IdWidth  response transaction ID.
- resp_i  in  2  AXI B resp code.
- out_valid_o  out  1  merged response available.
- out_ready_i  in  1  downstream accepts.
- out_id_o  out  IdWidth  merged transaction ID.
- out_resp_o  out  2  merged resp code.
- unmatched_o  out  1  one-cycle pulse: response dropped, no matching entry.

Behaviour:
- Per-entry state: vld, id, remaining (CntWidth), merged resp (2b). Allocation order is kept by head/tail pointers modulo MaxOutstanding, plus an occupancy count.
- Reset while rst_i=1 (synchronous):
  - All entries invalid; pointers and occupancy 0; merged resps 0.
  - expect_ready_o=0, resp_ready_o=0, out_valid_o=0, unmatched_o=0.
  - A reset mid-operation discards all pending state with no output.
- Allocation:
  - expect_ready_o = !rst_i && occupancy<MaxOutstanding && no valid entry with remaining>0 holds expect_id_i. Duplicate live IDs stall allocation.
  - On handshake, the tail entry loads id, remaining=expect_cnt_i, resp=OKAY; tail increments.
  - expect_cnt_i=0 creates an entry that is immediately complete with OKAY.
  - expect_cnt_i>NumDests is an assertion failure.
- Response:
  - resp_ready_o = !rst_i (always absorbs in one cycle).
  - On handshake, match against valid entries with remaining>0 and id==resp_id_i. At most one can match.
  - On a match: remaining decrements; merged resp becomes max(merged, resp_i) numerically (OKAY0 < EXOKAY1 < SLVERR2 < DECERR3).
  - No match: the response is dropped and unmatched_o pulses in the next cycle.
- Simultaneous allocation and response in the same cycle: the response matches only pre-existing entries, never the entry being written this cycle.
- Output:
  - out_valid_o = head entry valid && remaining==0, driven from registered state only.
  - out_id_o and out_resp_o come from the head entry and are stable while out_valid_o=1 && !out_ready_i.
  - On handshake, the head entry is freed and head increments.
  - Latency: final response accepted in cycle t gives out_valid_o=1 in cycle t+1.
  - A completed non-head entry waits for head (in-order release).
- Free and allocate in the same cycle: occupancy stays unchanged. A full table accepts a new registration only in the cycle after a free, since ready is computed from registered occupancy.
- Pointers wrap from MaxOutstanding-1 to 0.
- Assertions:
  - out_valid_o is stable until handshake.
  - No entry with remaining underflows.
  - Registered IDs are unique among live entries.

Decomposition:
- floo_pkg additions:
  - Resp-code localparams (RespOkay, RespExOkay, RespSlvErr, RespDecErr).
  - mcast_entry_t struct (vld, id, remaining, resp).
  - Function resp_merge(a,b).
- One sub-module: floo_mcast_id_cam. It is a combinational match of resp_id_i and expect_id_i against the entry array and returns one-hot hit vectors; the parent owns all state.

Test Plan:
- Register id=0x12, cnt=3; responses OKAY, SLVERR, OKAY on consecutive cycles -> out_valid_o one cycle after the third response, id 0x12, resp 2, single handshake.
- Register id=0x01 cnt=2 then id=0x02 cnt=1; respond 0x02 first, then 0x01 twice -> out 0x01 released first, then 0x02 in the next accepted cycle.
- Fill 4 entries with cnt=1 -> expect_ready_o=0. Complete and pop head -> expect_ready_o=1 the next cycle, new entry accepted at wrapped tail index 0.
- Response id=0x55 with no entry -> resp_ready_o=1, unmatched_o pulses once, no table change.
- Register id=0x07 cnt=0 -> out_valid_o next cycle with resp 0. Hold out_ready_i=0 for 5 cycles -> outputs stable.
- Register id=0x09 cnt=2, one response, assert rst_i for one cycle -> all outputs 0. A later response 0x09 yields unmatched_o, and no output appears.
